// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Stalls the front end while running, then strobes a one-cycle result for EX/MEM.
module muldiv_sequencer #(
    parameter int ITERATIONS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_start,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_operand1,
    input  logic [31:0] in_operand2,
    input  logic [4:0]  in_rd,
    input  logic        in_flush,
    output logic        out_stall,
    output logic        out_busy,
    output logic        out_done,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd
);
    localparam int CW = $clog2(ITERATIONS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [2:0]    funct3;
    logic [4:0]    rd;
    logic          sign_a, sign_b;
    logic [31:0]   opnd;       // multiplicand for multiply, divisor for divide
    logic [63:0]   prod;
    logic [32:0]   rem;
    logic [31:0]   quot;

    // Operand decode at the start of an instruction
    logic        signed1, signed2, neg1, neg2, div_zero, div_ovf;
    logic [31:0] abs1, abs2;

    always_comb begin
        signed1  = (in_funct3 != 3'b011) && (in_funct3 != 3'b101) && (in_funct3 != 3'b111);
        signed2  = signed1 && (in_funct3 != 3'b010);
        neg1     = signed1 && in_operand1[31];
        neg2     = signed2 && in_operand2[31];
        abs1     = neg1 ? -in_operand1 : in_operand1;
        abs2     = neg2 ? -in_operand2 : in_operand2;
        div_zero = in_funct3[2] && (in_operand2 == 32'd0);
        div_ovf  = in_funct3[2] && !in_funct3[0] &&
                   (in_operand1 == 32'h8000_0000) && (in_operand2 == 32'hFFFF_FFFF);
    end

    // One iteration of each datapath, plus the sign-corrected final result
    logic [32:0] add_sum, rem_shift, trial, rem_step;
    logic [63:0] prod_step, prod_fix;
    logic [31:0] quot_step, quot_fix, rem_fix, result_sel;

    always_comb begin
        add_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);
        prod_step = {add_sum, prod[31:1]};
        rem_shift = {rem[31:0], quot[31]};
        trial     = rem_shift - {1'b0, opnd};
        rem_step  = trial[32] ? rem_shift : trial;
        quot_step = {quot[30:0], ~trial[32]};
        prod_fix  = (sign_a ^ sign_b) ? -prod_step : prod_step;
        quot_fix  = (sign_a ^ sign_b) ? -quot_step : quot_step;
        rem_fix   = sign_a ? -rem_step[31:0] : rem_step[31:0];
        case (funct3)
            3'b000:                 result_sel = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: result_sel = prod_fix[63:32];
            3'b100, 3'b101:         result_sel = quot_fix;
            default:                result_sel = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            funct3     <= 3'b000;
            rd         <= 5'd0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            opnd       <= 32'd0;
            prod       <= 64'd0;
            rem        <= 33'd0;
            quot       <= 32'd0;
            out_result <= 32'd0;
            out_rd     <= 5'd0;
        end else if (in_flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_start) begin
                        funct3 <= in_funct3;
                        rd     <= in_rd;
                        sign_a <= neg1;
                        sign_b <= neg2;
                        if (div_zero || div_ovf) begin
                            out_rd     <= in_rd;
                            out_result <= div_zero ? (in_funct3[1] ? in_operand1 : 32'hFFFF_FFFF)
                                                   : (in_funct3[1] ? 32'd0 : 32'h8000_0000);
                            state      <= DONE;
                        end else begin
                            opnd  <= in_funct3[2] ? abs2 : abs1;
                            prod  <= {32'd0, abs2};
                            quot  <= abs1;
                            rem   <= 33'd0;
                            count <= CW'(ITERATIONS - 1);
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    prod <= prod_step;
                    rem  <= rem_step;
                    quot <= quot_step;
                    if (count == '0) begin
                        out_result <= result_sel;
                        out_rd     <= rd;
                        state      <= DONE;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // in_start during DONE is the departing instruction, so only IDLE may stall on it
    assign out_stall = !reset && !in_flush && ((state == IDLE && in_start) || state == RUN);
    assign out_busy  = (state == RUN);
    assign out_done  = !reset && !in_flush && (state == DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed RV32M cases plus random operations against an arithmetic model.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_start;
    logic [2:0]  in_funct3;
    logic [31:0] in_operand1, in_operand2;
    logic [4:0]  in_rd;
    logic        in_flush;
    logic        out_stall, out_busy, out_done;
    logic [31:0] out_result;
    logic [4:0]  out_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.ITERATIONS(32)) dut (
        .clk(clk), .reset(reset), .in_start(in_start), .in_funct3(in_funct3),
        .in_operand1(in_operand1), .in_operand2(in_operand2), .in_rd(in_rd),
        .in_flush(in_flush), .out_stall(out_stall), .out_busy(out_busy),
        .out_done(out_done), .out_result(out_result), .out_rd(out_rd)
    );

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 64'd0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = $urandom_range(0, 20);
            4: v = -($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Presents one instruction starting next cycle (cycle 0) and follows it to its done cycle.
    // Leaves in_start high on exit, as the departing instruction is still in ID/EX.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] expected, input string name);
        bit special;
        int lat;
        special = f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        lat = special ? 1 : 33;
        @(posedge clk); #1;
        in_start = 1'b1; in_flush = 1'b0;
        in_funct3 = f3; in_operand1 = a; in_operand2 = b; in_rd = rd;
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                in_operand1 = $urandom; in_operand2 = $urandom;
                in_rd = 5'($urandom); in_funct3 = 3'($urandom);
            end
            @(negedge clk);
            checks++;
            if (out_stall !== (c < lat)) begin
                errors++;
                $display("FAIL %s stall cycle %0d: got %b want %b", name, c, out_stall, (c < lat));
            end
            checks++;
            if (out_busy !== (!special && c >= 1 && c < lat)) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, c, out_busy, (!special && c >= 1 && c < lat));
            end
            checks++;
            if (out_done !== (c == lat)) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b want %b", name, c, out_done, (c == lat));
            end
            if (c == lat) begin
                checks++;
                if (out_result !== expected) begin
                    errors++;
                    $display("FAIL %s result: got %h want %h", name, out_result, expected);
                end
                checks++;
                if (out_rd !== rd) begin
                    errors++;
                    $display("FAIL %s rd: got %0d want %0d", name, out_rd, rd);
                end
            end
        end
    endtask

    task automatic go_idle(input string name);
        @(posedge clk); #1;
        in_start = 1'b0;
        @(negedge clk);
        checks++;
        if (out_stall !== 1'b0 || out_busy !== 1'b0 || out_done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: stall/busy/done got %b%b%b want 000", name, out_stall, out_busy, out_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_start = 1'b1; in_flush = 1'b0;
        in_funct3 = 3'd0; in_operand1 = 32'd3; in_operand2 = 32'd4; in_rd = 5'd9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_stall !== 1'b0 || out_busy !== 1'b0 || out_done !== 1'b0) begin
            errors++;
            $display("FAIL reset flags: stall/busy/done got %b%b%b want 000", out_stall, out_busy, out_done);
        end
        checks++;
        if (out_result !== 32'd0 || out_rd !== 5'd0) begin
            errors++;
            $display("FAIL reset data: result %h rd %0d want 0 0", out_result, out_rd);
        end
        @(posedge clk); #1;
        reset = 1'b0; in_start = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  f3s  [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] as   [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                   32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs   [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                                   32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                   32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 12; i++) begin
            run_op(f3s[i], as[i], bs[i], 5'(i + 3), exps[i], $sformatf("directed%0d", i));
            go_idle($sformatf("directed%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        run_op(3'd0, 32'd1234, 32'd5678, 5'd1, 32'd7006652, "b2b_first");
        run_op(3'd5, 32'd1000, 32'd3, 5'd2, 32'd333, "b2b_second");
        go_idle("b2b");
    endtask

    task automatic test_random();
        logic [2:0] f3;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom);
            a = pick_operand();
            b = pick_operand();
            run_op(f3, a, b, 5'($urandom), ref_result(f3, a, b), $sformatf("rand%0d_f%0d", i, f3));
            if ($urandom_range(0, 1) == 1) go_idle($sformatf("rand%0d", i));
        end
        go_idle("rand_end");
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        in_start = 1'b1; in_funct3 = 3'd4; in_operand1 = 32'd1000; in_operand2 = 32'd3; in_rd = 5'd7;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (c == 10) in_flush = 1'b1;
            @(negedge clk);
            checks++;
            if (out_stall !== (c < 10)) begin
                errors++;
                $display("FAIL flush stall cycle %0d: got %b want %b", c, out_stall, (c < 10));
            end
            checks++;
            if (out_done !== 1'b0) begin
                errors++;
                $display("FAIL flush done cycle %0d: got %b want 0", c, out_done);
            end
        end
        run_op(3'd0, 32'hFFFF_FFF0, 32'd3, 5'd11, 32'hFFFF_FFD0, "after_flush_mul");
        go_idle("after_flush");
        // Flush beats a start seen in IDLE
        @(posedge clk); #1;
        in_start = 1'b1; in_flush = 1'b1; in_funct3 = 3'd0;
        @(negedge clk);
        checks++;
        if (out_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle stall: got %b want 0", out_stall);
        end
        @(posedge clk); #1;
        in_start = 1'b0; in_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (out_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle busy: got %b want 0", out_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        @(posedge clk); #1;
        in_start = 1'b1; in_funct3 = 3'd0; in_operand1 = 32'd9; in_operand2 = 32'd9; in_rd = 5'd20;
        for (int c = 1; c <= 5; c++) begin @(posedge clk); #1; end
        reset = 1'b1; in_start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_stall !== 1'b0 || out_busy !== 1'b0 || out_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset flags: stall/busy/done got %b%b%b want 000", out_stall, out_busy, out_done);
        end
        checks++;
        if (out_result !== 32'd0 || out_rd !== 5'd0) begin
            errors++;
            $display("FAIL midreset data: result %h rd %0d want 0 0", out_result, out_rd);
        end
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            checks++;
            if (out_done !== 1'b0) begin
                errors++;
                $display("FAIL midreset late done cycle %0d: got %b want 0", c, out_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
